ula_seq: RTL and testbench



---
 rtl/ula_seq.sv | 159 +++++++++++++++
 tb/tb_ula_seq.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ula_seq.sv
// ula_seq: parametrised sequential ALU. Logic, add/sub and shifts complete
// in one cycle. Unsigned multiply runs shift-add, one multiplier bit per
// clock. Results and flags are registered and are announced by a one-cycle
// ula_ack pulse.
module ula_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [3:0]       op_sel,
  output logic [WIDTH-1:0] res,
  output logic             carry,
  output logic             zero,
  output logic             ovf,
  output logic             busy,
  output logic             ula_ack
);

  localparam int SW = $clog2(WIDTH);

  typedef enum logic [0:0] {S_IDLE, S_MUL} state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   res_q;
  logic               carry_q;
  logic               zero_q;
  logic               ovf_q;
  logic               busy_q;
  logic               ack_q;

  // Multiply working set. The multiplicand is shifted left and the
  // multiplier right, so every step only examines multiplier bit 0.
  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [SW-1:0]      cnt_q;

  logic [2*WIDTH-1:0] prod_d;
  logic [WIDTH-1:0]   alu_res_d;
  logic               alu_c_d;
  logic               alu_v_d;
  logic [WIDTH:0]     sum_ext;
  logic [WIDTH:0]     dif_ext;
  logic [WIDTH:0]     shl_ext;
  logic [WIDTH:0]     shr_ext;
  logic [SW-1:0]      shamt;

  assign shamt = op2[SW-1:0];

  // Partial product after folding in the current multiplier bit.
  assign prod_d = acc_q + (mplier_q[0] ? mcand_q : '0);

  // Single-cycle datapath, evaluated on the live operands.
  always_comb begin
    alu_res_d = '0;
    alu_c_d   = 1'b0;
    alu_v_d   = 1'b0;
    sum_ext   = {1'b0, op1} + {1'b0, op2};
    dif_ext   = {1'b0, op1} - {1'b0, op2};
    // One guard bit on the outgoing side catches the last bit shifted out;
    // a zero shift leaves the guard bit clear, so carry is 0.
    shl_ext   = {1'b0, op1} << shamt;
    shr_ext   = {op1, 1'b0} >> shamt;
    casez (op_sel)
      4'b0100: alu_res_d = op1 | op2;
      4'b0101: alu_res_d = op1 & op2;
      4'b0110: alu_res_d = op1 ^ op2;
      4'b0111: alu_res_d = ~(op1 & op2);
      4'b10??: begin
        alu_res_d = sum_ext[WIDTH-1:0];
        alu_c_d   = sum_ext[WIDTH];
        alu_v_d   = (op1[WIDTH-1] == op2[WIDTH-1]) &&
                    (sum_ext[WIDTH-1] != op1[WIDTH-1]);
      end
      4'b11??: begin
        alu_res_d = dif_ext[WIDTH-1:0];
        alu_c_d   = dif_ext[WIDTH];
        alu_v_d   = (op1[WIDTH-1] != op2[WIDTH-1]) &&
                    (dif_ext[WIDTH-1] != op1[WIDTH-1]);
      end
      4'b0010: begin
        alu_res_d = shl_ext[WIDTH-1:0];
        alu_c_d   = shl_ext[WIDTH];
      end
      4'b0011: begin
        alu_res_d = shr_ext[WIDTH:1];
        alu_c_d   = shr_ext[0];
      end
      default: ;
    endcase
  end

  // Control FSM with registered results, flags, busy and ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      res_q    <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      ack_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (ena) begin
            if (op_sel == 4'b0001) begin
              state_q  <= S_MUL;
              busy_q   <= 1'b1;
              mcand_q  <= {{WIDTH{1'b0}}, op1};
              mplier_q <= op2;
              acc_q    <= '0;
              cnt_q    <= '0;
            end else begin
              res_q   <= alu_res_d;
              carry_q <= alu_c_d;
              ovf_q   <= alu_v_d;
              zero_q  <= (alu_res_d == '0);
              ack_q   <= 1'b1;
            end
          end
        end
        S_MUL: begin
          if (cnt_q == SW'(WIDTH - 1)) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            ack_q   <= 1'b1;
            res_q   <= prod_d[WIDTH-1:0];
            carry_q <= 1'b0;
            ovf_q   <= |prod_d[2*WIDTH-1:WIDTH];
            zero_q  <= (prod_d[WIDTH-1:0] == '0);
          end else begin
            acc_q    <= prod_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + SW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign res     = res_q;
  assign carry   = carry_q;
  assign zero    = zero_q;
  assign ovf     = ovf_q;
  assign busy    = busy_q;
  assign ula_ack = ack_q;

endmodule

// File: tb/tb_ula_seq.sv
// tb_ula_seq: randomized and directed checks of ula_seq against an
// arithmetic reference model.
module tb_ula_seq;

  localparam int W = 8;
  localparam longint MOD  = 64'd1 << W;
  localparam longint HALF = MOD / 2;

  logic         clk;
  logic         rst;
  logic         ena;
  logic [W-1:0] op1;
  logic [W-1:0] op2;
  logic [3:0]   op_sel;
  logic [W-1:0] res;
  logic         carry;
  logic         zero;
  logic         ovf;
  logic         busy;
  logic         ula_ack;

  int checks = 0;
  int errors = 0;

  ula_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .ena(ena), .op1(op1), .op2(op2), .op_sel(op_sel),
    .res(res), .carry(carry), .zero(zero), .ovf(ovf), .busy(busy),
    .ula_ack(ula_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: {res, carry, zero, ovf} from plain integer arithmetic.
  function automatic logic [W+2:0] model(input logic [3:0] op,
                                         input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    longint ua, ub, sa, sb, r, c, v, t, amt;
    logic [W-1:0] rr;
    ua = longint'(a);
    ub = longint'(b);
    sa = (ua >= HALF) ? ua - MOD : ua;
    sb = (ub >= HALF) ? ub - MOD : ub;
    r = 0; c = 0; v = 0;
    amt = ub % W;
    casez (op)
      4'b0100: r = ua | ub;
      4'b0101: r = ua & ub;
      4'b0110: r = ua ^ ub;
      4'b0111: r = (~(ua & ub)) & (MOD - 1);
      4'b10??: begin
        t = ua + ub; r = t % MOD; c = (t >= MOD) ? 1 : 0;
        t = sa + sb; v = (t > HALF - 1 || t < -HALF) ? 1 : 0;
      end
      4'b11??: begin
        r = (ua - ub + MOD) % MOD; c = (ua < ub) ? 1 : 0;
        t = sa - sb; v = (t > HALF - 1 || t < -HALF) ? 1 : 0;
      end
      4'b0010: begin
        r = (ua << amt) % MOD;
        c = (amt == 0) ? 0 : (ua >> (W - amt)) & 1;
      end
      4'b0011: begin
        r = ua >> amt;
        c = (amt == 0) ? 0 : (ua >> (amt - 1)) & 1;
      end
      4'b0001: begin
        t = ua * ub; r = t % MOD; v = (t >= MOD) ? 1 : 0;
      end
      default: ;
    endcase
    rr = r[W-1:0];
    return {rr, c[0], (r == 0), v[0]};
  endfunction

  function automatic logic [W+4:0] observe();
    return {ula_ack, busy, res, carry, zero, ovf};
  endfunction

  // Present one op with ena for a single edge and return the outputs
  // sampled just after that edge.
  task automatic do_single(input logic [3:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, output logic [W+4:0] obs);
    op_sel = op; op1 = a; op2 = b; ena = 1'b1;
    @(posedge clk); #1;
    ena = 1'b0;
    obs = observe();
  endtask

  task automatic test_reset();
    logic [W+4:0] obs;
    rst = 1'b1; ena = 1'b1; op_sel = 4'b1000; op1 = 8'd5; op2 = 8'd6;
    repeat (2) begin
      @(posedge clk); #1;
      obs = observe();
      checks++;
      if (obs !== '0) begin
        errors++;
        $display("FAIL reset got=%h exp=%h", obs, {(W+5){1'b0}});
      end
    end
    rst = 1'b0; ena = 1'b0;
  endtask

  task automatic test_arith();
    logic [3:0] ops [4] = '{4'b1000, 4'b1000, 4'b1111, 4'b1100};
    logic [W-1:0] as [4] = '{8'd200, 8'd100, 8'd5, 8'd9};
    logic [W-1:0] bs [4] = '{8'd100, 8'd100, 8'd9, 8'd9};
    logic [W+4:0] obs, exp, held;
    logic [3:0] op;
    logic [W-1:0] a, b;
    for (int i = 0; i < 24; i++) begin
      if (i < 4) begin
        op = ops[i]; a = as[i]; b = bs[i];
      end else begin
        op = {1'b1, 1'($urandom), 2'($urandom)};
        a = W'($urandom); b = W'($urandom);
      end
      do_single(op, a, b, obs);
      exp = {2'b10, model(op, a, b)};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL arith op=%b a=%0d b=%0d got=%h exp=%h", op, a, b, obs, exp);
      end
      @(posedge clk); #1;
      held = observe();
      checks++;
      if (held !== {2'b00, exp[W+2:0]}) begin
        errors++;
        $display("FAIL arith_hold op=%b got=%h exp=%h", op, held, {2'b00, exp[W+2:0]});
      end
    end
  endtask

  task automatic test_logic();
    logic [3:0] ops [3] = '{4'b0100, 4'b0111, 4'b0000};
    logic [W-1:0] as [3] = '{8'hA0, 8'hFF, 8'd7};
    logic [W-1:0] bs [3] = '{8'h05, 8'hFF, 8'd2};
    logic [W+4:0] obs, exp;
    logic [3:0] op;
    logic [W-1:0] a, b;
    for (int i = 0; i < 15; i++) begin
      if (i < 3) begin
        op = ops[i]; a = as[i]; b = bs[i];
      end else begin
        op = {2'b01, 2'($urandom)};
        a = W'($urandom); b = W'($urandom);
      end
      do_single(op, a, b, obs);
      exp = {2'b10, model(op, a, b)};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL logic op=%b a=%0d b=%0d got=%h exp=%h", op, a, b, obs, exp);
      end
    end
  endtask

  task automatic test_shift();
    logic [3:0] ops [3] = '{4'b0010, 4'b0011, 4'b0010};
    logic [W-1:0] as [3] = '{8'h81, 8'h81, 8'h5B};
    logic [W-1:0] bs [3] = '{8'd1, 8'd3, 8'd0};
    logic [W+4:0] obs, exp;
    logic [3:0] op;
    logic [W-1:0] a, b;
    for (int i = 0; i < 19; i++) begin
      if (i < 3) begin
        op = ops[i]; a = as[i]; b = bs[i];
      end else begin
        op = {3'b001, 1'($urandom)};
        a = W'($urandom); b = W'($urandom);
      end
      do_single(op, a, b, obs);
      exp = {2'b10, model(op, a, b)};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL shift op=%b a=%0d b=%0d got=%h exp=%h", op, a, b, obs, exp);
      end
    end
  endtask

  // One multiply; with noise, ena/operands/op_sel are scrambled while busy
  // and an ADD is offered on the completing edge, all of which must be ignored.
  task automatic test_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit noise);
    logic [W+4:0] obs, exp;
    logic [W-1:0] prev;
    prev = res;
    exp = {2'b10, model(4'b0001, a, b)};
    op_sel = 4'b0001; op1 = a; op2 = b; ena = 1'b1;
    @(posedge clk); #1;
    ena = 1'b0;
    for (int cyc = 0; cyc < W; cyc++) begin
      checks++;
      if ({ula_ack, busy, res} !== {2'b01, prev}) begin
        errors++;
        $display("FAIL mul_busy cyc=%0d a=%0d b=%0d got=%b/%b/%0d exp=0/1/%0d",
                 cyc, a, b, ula_ack, busy, res, prev);
      end
      if (noise) begin
        ena = 1'($urandom); op1 = W'($urandom); op2 = W'($urandom);
        op_sel = 4'($urandom);
        if (cyc == W - 1) begin
          ena = 1'b1; op_sel = 4'b1000;
        end
      end
      @(posedge clk); #1;
    end
    obs = observe();
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL mul_done a=%0d b=%0d got=%h exp=%h", a, b, obs, exp);
    end
    ena = 1'b0;
    @(posedge clk); #1;
    obs = observe();
    checks++;
    if (obs !== {2'b00, exp[W+2:0]}) begin
      errors++;
      $display("FAIL mul_after a=%0d b=%0d got=%h exp=%h", a, b, obs, {2'b00, exp[W+2:0]});
    end
  endtask

  task automatic test_abort();
    logic [W+4:0] obs, exp;
    op_sel = 4'b0001; op1 = 8'd200; op2 = 8'd3; ena = 1'b1;
    @(posedge clk); #1;
    ena = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    obs = observe();
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL abort_reset got=%h exp=%h", obs, {(W+5){1'b0}});
    end
    do_single(4'b1000, 8'd1, 8'd2, obs);
    exp = {2'b10, model(4'b1000, 8'd1, 8'd2)};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL abort_add got=%h exp=%h", obs, exp);
    end
    for (int i = 0; i < W + 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if (ula_ack !== 1'b0 || res !== 8'd3) begin
        errors++;
        $display("FAIL abort_quiet cyc=%0d ack=%b res=%0d exp ack=0 res=3", i, ula_ack, res);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W+4:0] obs, exp;
    logic [3:0] op;
    logic [W-1:0] a, b;
    ena = 1'b1;
    for (int i = 0; i < 10; i++) begin
      op = (i < 4) ? 4'b1000 : {1'b1, 1'($urandom), 2'($urandom)};
      a = W'($urandom); b = W'($urandom);
      op_sel = op; op1 = a; op2 = b;
      exp = {2'b10, model(op, a, b)};
      @(posedge clk); #1;
      obs = observe();
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL b2b i=%0d op=%b a=%0d b=%0d got=%h exp=%h", i, op, a, b, obs, exp);
      end
    end
    ena = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ula_ack !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drop ack=%b exp=0", ula_ack);
    end
  endtask

  initial begin
    rst = 1'b1; ena = 1'b0; op1 = '0; op2 = '0; op_sel = '0;
    test_reset();
    test_arith();
    test_logic();
    test_shift();
    test_mul(8'd13, 8'd11, 1'b0);
    test_mul(8'd20, 8'd20, 1'b0);
    test_mul(8'd13, 8'd11, 1'b1);
    for (int i = 0; i < 6; i++) test_mul(W'($urandom), W'($urandom), 1'b1);
    test_mul(8'd0, 8'd77, 1'b0);
    test_mul(8'd255, 8'd255, 1'b1);
    test_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
